dpram_pipe: RTL and testbench
=============================

DPRAM_PIPE -- requirements
Module: dpram_pipe

Interface
REQ-001 SHALL have parameter DSIZE, default 32: data width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ASIZE, default 4: address width; depth = 2**ASIZE words.
REQ-003 SHALL have parameter RD_LAT, default 1: read latency in cycles; legal values 1 or 2.
REQ-004 SHALL have parameter BYPASS, default 1: on a same-address read/write collision, 1 returns new data and 0 returns old data.
REQ-005 SHALL have parameter INIT_CLEAR, default 1: 1 zero-fills the memory after reset.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port wr_en, input, 1 bit: write request.
REQ-009 SHALL have port wr_addr, input, ASIZE bits: write address.
REQ-010 SHALL have port wr_data, input, DSIZE bits: write data.
REQ-011 SHALL have port wr_be, input, DSIZE/8 bits: byte enables; bit i enables byte lane [8i+7:8i].
REQ-012 SHALL have port rd_en, input, 1 bit: read request.
REQ-013 SHALL have port rd_addr, input, ASIZE bits: read address.
REQ-014 SHALL have port rd_data, output, DSIZE bits: registered read data.
REQ-015 SHALL have port rd_valid, output, 1 bit: rd_data carries a fresh read result this cycle.
REQ-016 SHALL have port init_busy, output, 1 bit: clear sequence in progress; requests are ignored while it is high.

Function
REQ-017 SHALL use a two-state FSM: ST_CLEAR and ST_READY.
REQ-018 SHALL enter ST_CLEAR on reset when INIT_CLEAR=1, and enter ST_READY on reset when INIT_CLEAR=0.
REQ-019 In ST_CLEAR, SHALL write all-zero to address 0, 1, ..., 2**ASIZE-1, one address per cycle, using an ASIZE-bit counter.
REQ-020 SHALL move from ST_CLEAR to ST_READY on the cycle after address 2**ASIZE-1 is written; init_busy is high for exactly 2**ASIZE cycles after reset release.
REQ-021 init_busy SHALL be 1 in ST_CLEAR and 0 in ST_READY.
REQ-022 While init_busy=1, SHALL ignore wr_en and rd_en: no memory update, no rd_valid.
REQ-023 Write: when wr_en=1 and in ST_READY, SHALL update at the rising edge only the byte lanes with wr_be[i]=1; wr_be=0 leaves the word unchanged.
REQ-024 Read: rd_en=1 in ST_READY SHALL produce rd_data and rd_valid=1 exactly RD_LAT cycles later.
REQ-025 Reads SHALL be fully pipelined: one read accepted per cycle, results returned in issue order.
REQ-026 SHALL hold rd_data at its last value when no result is due; rd_valid SHALL be 0 in those cycles.
REQ-027 Collision (rd_en and wr_en in the same cycle, rd_addr==wr_addr), BYPASS=1: returned word SHALL be the old word with enabled lanes replaced by wr_data.
REQ-028 Collision, BYPASS=0: returned word SHALL be the pre-write content.
REQ-029 A write at cycle t SHALL be visible to any read issued at cycle t+1 or later, for both BYPASS values.
REQ-030 Illegal RD_LAT or DSIZE (not a multiple of 8) SHALL fail elaboration.

Reset
REQ-031 While rst_n=0 at a clock edge: rd_data=0, rd_valid=0, read pipeline flushed, FSM to the initial state of REQ-018, clear counter=0.
REQ-032 init_busy SHALL read 1 during reset when INIT_CLEAR=1, and 0 when INIT_CLEAR=0.
REQ-033 Reset asserted mid-clear or mid-read SHALL abort the operation; in-flight read results SHALL never appear.
REQ-034 Memory contents SHALL not be reset directly; with INIT_CLEAR=1 they are zeroed only by the clear sequence.

Structure
REQ-035 Shared package dpram_pkg SHALL hold the FSM state type (ST_CLEAR, ST_READY) and the RD_LAT_MIN=1 and RD_LAT_MAX=2 constants.
REQ-036 SHALL instantiate one sub-module, dpram_rd_pipe, parameterised by DSIZE and RD_LAT, which carries the read data/valid registers and the flush on reset.
REQ-037 Memory array, byte-lane write merge, collision mux and FSM SHALL reside in dpram_pipe.

Verification (DSIZE=32, ASIZE=4)
REQ-038 Release reset, INIT_CLEAR=1 -> init_busy high 16 cycles; subsequent reads of addresses 0..15 return 0x00000000.
REQ-039 Write 0xDEADBEEF to address 3 with be=0xF, then 0x000000AA with be=0x1; read address 3 -> 0xDEADBEAA after RD_LAT cycles with rd_valid=1.
REQ-040 Address 5 holds 0x11111111; write 0x22222222 with be=0xF and read address 5 in the same cycle -> 0x22222222 for BYPASS=1, 0x11111111 for BYPASS=0.
REQ-041 RD_LAT=2; back-to-back reads of addresses 0..3 holding 0xA0..0xA3 -> rd_valid high 4 consecutive cycles starting 2 cycles after the first read, data 0xA0, 0xA1, 0xA2, 0xA3 in order.
REQ-042 rst_n low on the 7th clear cycle, with wr_en=1 during clear -> clear restarts, init_busy high 16 cycles after release, memory all zero, the ignored write absent.
REQ-043 rst_n low with a read in flight -> rd_valid never asserts for that read; rd_data=0x00000000.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared state type and read-latency limits for the dual-port RAM.
package dpram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/dpram_pipe_if.sv
// Write/read request bus of dpram_pipe plus its status outputs.
interface dpram_pipe_if #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 4
);
  logic               wr_en;
  logic [ASIZE-1:0]   wr_addr;
  logic [DSIZE-1:0]   wr_data;
  logic [DSIZE/8-1:0] wr_be;
  logic               rd_en;
  logic [ASIZE-1:0]   rd_addr;
  logic [DSIZE-1:0]   rd_data;
  logic               rd_valid;
  logic               init_busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, init_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, init_busy
  );
endinterface

// File: rtl/dpram_rd_pipe.sv
// Read result pipeline: RD_LAT register stages; rd_data holds its last value
// when no result is due, and everything in flight is dropped on reset.
module dpram_rd_pipe
  import dpram_pkg::*;
#(
  parameter int DSIZE  = 32,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] in_data,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_valid
);

  logic             s1_valid;
  logic [DSIZE-1:0] s1_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) s1_data <= in_data;
    end
  end

  if (RD_LAT == RD_LAT_MAX) begin : g_two
    logic             s2_valid;
    logic [DSIZE-1:0] s2_data;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign rd_valid = s2_valid;
    assign rd_data  = s2_data;
  end else begin : g_one
    assign rd_valid = s1_valid;
    assign rd_data  = s1_data;
  end

endmodule

// File: rtl/dpram_pipe.sv
// Simple dual-port RAM with byte-lane writes, pipelined reads, selectable
// collision behaviour and an optional zero-fill sequence after reset.
//   state    | meaning
//   ST_CLEAR | zero-filling one address per cycle, requests ignored
//   ST_READY | normal read/write service
module dpram_pipe
  import dpram_pkg::*;
#(
  parameter int DSIZE      = 32,
  parameter int ASIZE      = 4,
  parameter int RD_LAT     = 1,
  parameter int BYPASS     = 1,
  parameter int INIT_CLEAR = 1
) (
  input logic         clk,
  input logic         rst_n,
  dpram_pipe_if.slave bus
);

  localparam int DEPTH = 2 ** ASIZE;
  localparam int NBYTE = DSIZE / 8;
  localparam logic [ASIZE-1:0] LAST_ADDR = ASIZE'(DEPTH - 1);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("dpram_pipe: RD_LAT=%0d must lie in [%0d,%0d]", RD_LAT, RD_LAT_MIN, RD_LAT_MAX);
  end
  if (DSIZE < 8 || DSIZE % 8 != 0) begin : g_bad_dsize
    $error("dpram_pipe: DSIZE=%0d must be a non-zero multiple of 8", DSIZE);
  end

  state_t           state;
  logic [ASIZE-1:0] clr_cnt;
  logic             init_busy_q;
  logic [DSIZE-1:0] mem [DEPTH];

  logic             wr_go;
  logic             rd_go;
  logic             collide;
  logic [DSIZE-1:0] wr_old;
  logic [DSIZE-1:0] wr_merged;
  logic [DSIZE-1:0] rd_word;

  assign wr_go   = bus.wr_en && (state == ST_READY);
  assign rd_go   = bus.rd_en && (state == ST_READY);
  assign collide = wr_go && rd_go && (bus.wr_addr == bus.rd_addr);
  assign wr_old  = mem[bus.wr_addr];

  for (genvar i = 0; i < NBYTE; i++) begin : g_lane
    assign wr_merged[8*i +: 8] = bus.wr_be[i] ? bus.wr_data[8*i +: 8] : wr_old[8*i +: 8];
  end

  // On a collision the merged word is exactly what the array will hold next cycle.
  assign rd_word = (BYPASS != 0 && collide) ? wr_merged : mem[bus.rd_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      init_busy_q <= (INIT_CLEAR != 0);
      clr_cnt     <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state       <= ST_READY;
            init_busy_q <= 1'b0;
          end
        end
        default: init_busy_q <= 1'b0;
      endcase
    end
  end

  // The array itself is never reset; only the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (wr_go) begin
        mem[bus.wr_addr] <= wr_merged;
      end
    end
  end

  dpram_rd_pipe #(
    .DSIZE  (DSIZE),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_go),
    .in_data  (rd_word),
    .rd_data  (bus.rd_data),
    .rd_valid (bus.rd_valid)
  );

  assign bus.init_busy = init_busy_q;

endmodule

// File: tb/tb_dpram_pipe.sv
// Bench for dpram_pipe: three configurations driven with identical stimulus,
// checked against a queue-based memory model, a vector table and directed sequences.
module tb_dpram_pipe;

  localparam int N = 3;
  localparam int LAT [N] = '{1, 2, 1};
  localparam int BYP [N] = '{1, 0, 0};
  localparam int ICL [N] = '{1, 1, 0};

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          known;
  } rd_item_t;

  typedef struct {
    bit          we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          re;
    logic [3:0]  ra;
    logic [31:0] exp_b1;
    logic [31:0] exp_b0;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic [31:0] dout  [N];
  logic        dval  [N];
  logic        dbusy [N];

  dpram_pipe_if #(.DSIZE(32), .ASIZE(4)) ifs [N] ();

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign ifs[g].wr_en   = wr_en;
    assign ifs[g].wr_addr = wr_addr;
    assign ifs[g].wr_data = wr_data;
    assign ifs[g].wr_be   = wr_be;
    assign ifs[g].rd_en   = rd_en;
    assign ifs[g].rd_addr = rd_addr;
    assign dout[g]  = ifs[g].rd_data;
    assign dval[g]  = ifs[g].rd_valid;
    assign dbusy[g] = ifs[g].init_busy;

    dpram_pipe #(
      .DSIZE      (32),
      .ASIZE      (4),
      .RD_LAT     (LAT[g]),
      .BYPASS     (BYP[g]),
      .INIT_CLEAR (ICL[g])
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifs[g])
    );
  end

  int          cyc;
  int          n_cmp;
  int          n_err;
  int          busy_left [N];
  logic [31:0] mm        [N][16];
  bit          mk        [N][16];
  rd_item_t    pq        [N][$];
  logic [31:0] exp_data  [N];
  bit          exp_known [N];
  logic [31:0] last_rd   [N];
  int          vcnt      [N];
  logic        obs_valid [N];
  logic        obs_busy  [N];
  logic [31:0] obs_data  [N];
  vec_t        tbl       [10];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~m) | (w & m);
  endfunction

  task automatic cmp(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc %0d: got %h want %h", name, k, cyc, act, exp);
    end
  endtask

  // Reference: clear takes 16 edges and leaves the array zero; reads see
  // pre-write content unless bypassing; results appear RD_LAT-1 edges after acceptance.
  task automatic model_edge();
    rd_item_t it;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        busy_left[k] = (ICL[k] != 0) ? 16 : 0;
        pq[k].delete();
        exp_data[k]  = '0;
        exp_known[k] = 1'b1;
      end else if (busy_left[k] > 0) begin
        busy_left[k]--;
        if (busy_left[k] == 0) begin
          for (int a = 0; a < 16; a++) begin
            mm[k][a] = '0;
            mk[k][a] = 1'b1;
          end
        end
      end else begin
        if (rd_en) begin
          it.due   = cyc + LAT[k] - 1;
          it.data  = mm[k][rd_addr];
          it.known = mk[k][rd_addr];
          if (BYP[k] != 0 && wr_en && wr_addr == rd_addr) begin
            it.data  = merge(it.data, wr_data, wr_be);
            it.known = it.known || (wr_be == 4'hF);
          end
          pq[k].push_back(it);
        end
        if (wr_en) begin
          mm[k][wr_addr] = merge(mm[k][wr_addr], wr_data, wr_be);
          mk[k][wr_addr] = mk[k][wr_addr] || (wr_be == 4'hF);
        end
      end
    end
  endtask

  task automatic check_outputs();
    rd_item_t it;
    bit ev;
    for (int k = 0; k < N; k++) begin
      ev = 1'b0;
      if (pq[k].size() > 0 && pq[k][0].due == cyc) begin
        it = pq[k].pop_front();
        ev = 1'b1;
        exp_data[k]  = it.data;
        exp_known[k] = it.known;
      end
      obs_valid[k] = dval[k];
      obs_busy[k]  = dbusy[k];
      obs_data[k]  = dout[k];
      cmp("init_busy", k, 32'(dbusy[k]), 32'(busy_left[k] > 0));
      cmp("rd_valid", k, 32'(dval[k]), 32'(ev));
      if (exp_known[k]) cmp("rd_data", k, dout[k], exp_data[k]);
      if (dval[k]) begin
        last_rd[k] = dout[k];
        vcnt[k]++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic clr_vcnt();
    for (int k = 0; k < N; k++) vcnt[k] = 0;
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (obs_busy[0] && n < 40);
    cmp(name, 0, n, 16);
  endtask

  task automatic read_all(input string name);
    idle();
    clr_vcnt();
    for (int a = 0; a < 16; a++) begin
      rd_en   = 1'b1;
      rd_addr = 4'(a);
      cycle();
    end
    idle();
    cycle();
    cycle();
    cmp(name, 0, vcnt[0], 16);
    cmp(name, 1, vcnt[1], 16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc   = 0;
    n_cmp = 0;
    n_err = 0;
    for (int k = 0; k < N; k++) begin
      busy_left[k] = 0;
      exp_data[k]  = '0;
      exp_known[k] = 1'b0;
      vcnt[k]      = 0;
      last_rd[k]   = '0;
      for (int a = 0; a < 16; a++) begin
        mm[k][a] = '0;
        mk[k][a] = 1'b0;
      end
    end

    tbl[0] = '{1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, 4'd0, 32'h0, 32'h0};
    tbl[1] = '{1'b1, 4'd3, 32'h000000AA, 4'h1, 1'b0, 4'd0, 32'h0, 32'h0};
    tbl[2] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd3, 32'hDEADBEAA, 32'hDEADBEAA};
    tbl[3] = '{1'b1, 4'd5, 32'h11111111, 4'hF, 1'b0, 4'd0, 32'h0, 32'h0};
    tbl[4] = '{1'b1, 4'd5, 32'h22222222, 4'hF, 1'b1, 4'd5, 32'h22222222, 32'h11111111};
    tbl[5] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd5, 32'h22222222, 32'h22222222};
    tbl[6] = '{1'b1, 4'd7, 32'h12345678, 4'h0, 1'b1, 4'd7, 32'h00000000, 32'h00000000};
    tbl[7] = '{1'b1, 4'd6, 32'hCAFEF00D, 4'hA, 1'b1, 4'd6, 32'hCA00F000, 32'h00000000};
    tbl[8] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd6, 32'hCA00F000, 32'hCA00F000};
    tbl[9] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd7, 32'h00000000, 32'h00000000};

    rst_n   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_be   = '0;
    rd_addr = '0;
    idle();
    cycle();
    cycle();
    cmp("reset_rd_data", 0, obs_data[0], 32'h0);
    cmp("reset_busy_noclear", 2, 32'(obs_busy[2]), 32'h0);
    rst_n = 1'b1;
    wait_clear("clear_len");
    read_all("clear_reads");

    for (int i = 0; i < 10; i++) begin
      wr_en   = tbl[i].we;
      wr_addr = tbl[i].wa;
      wr_data = tbl[i].wd;
      wr_be   = tbl[i].be;
      rd_en   = tbl[i].re;
      rd_addr = tbl[i].ra;
      clr_vcnt();
      cycle();
      idle();
      cycle();
      cycle();
      if (tbl[i].re) begin
        for (int k = 0; k < 2; k++) begin
          cmp($sformatf("vec%0d_cnt", i), k, vcnt[k], 1);
          cmp($sformatf("vec%0d_data", i), k, last_rd[k],
              (BYP[k] != 0) ? tbl[i].exp_b1 : tbl[i].exp_b0);
        end
      end else begin
        cmp($sformatf("vec%0d_noread", i), 0, vcnt[0], 0);
      end
    end

    // Back-to-back reads through the two-stage configuration
    for (int a = 0; a < 4; a++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(a);
      wr_data = 32'hA0 + 32'(a);
      wr_be   = 4'hF;
      cycle();
    end
    idle();
    cycle();
    for (int a = 0; a < 4; a++) begin
      rd_en   = 1'b1;
      rd_addr = 4'(a);
      cycle();
      if (a == 0) begin
        cmp("b2b_first_gap", 1, 32'(obs_valid[1]), 32'h0);
      end else begin
        cmp("b2b_valid", 1, 32'(obs_valid[1]), 32'h1);
        cmp("b2b_data", 1, obs_data[1], 32'hA0 + 32'(a - 1));
      end
    end
    idle();
    cycle();
    cmp("b2b_valid", 1, 32'(obs_valid[1]), 32'h1);
    cmp("b2b_data", 1, obs_data[1], 32'hA3);
    cycle();
    cmp("b2b_tail", 1, 32'(obs_valid[1]), 32'h0);
    cmp("b2b_hold", 1, obs_data[1], 32'hA3);

    // Reset on the 7th clear cycle with requests asserted throughout
    rst_n = 1'b0;
    cycle();
    rst_n   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'd9;
    wr_data = 32'hFFFFFFFF;
    wr_be   = 4'hF;
    rd_en   = 1'b1;
    rd_addr = 4'd9;
    for (int i = 0; i < 6; i++) begin
      cycle();
      cmp("midclear_busy", 0, 32'(obs_busy[0]), 32'h1);
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    wait_clear("reclear_len");
    idle();
    read_all("reclear_reads");
    rd_en   = 1'b1;
    rd_addr = 4'd9;
    cycle();
    idle();
    cycle();
    cycle();
    cmp("ignored_write", 0, last_rd[0], 32'h0);
    cmp("ignored_write", 1, last_rd[1], 32'h0);

    // Reset with a read in flight in the two-stage configuration
    wr_en   = 1'b1;
    wr_addr = 4'd3;
    wr_data = 32'h5A5A5A5A;
    wr_be   = 4'hF;
    cycle();
    idle();
    rd_en   = 1'b1;
    rd_addr = 4'd3;
    clr_vcnt();
    cycle();
    idle();
    rst_n = 1'b0;
    cycle();
    cmp("flush_valid", 1, 32'(obs_valid[1]), 32'h0);
    cmp("flush_data", 1, obs_data[1], 32'h0);
    cmp("flush_data", 0, obs_data[0], 32'h0);
    rst_n = 1'b1;
    wait_clear("flush_reclear_len");
    cmp("flush_no_result", 1, vcnt[1], 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      rst_n   = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      wr_be   = 4'($urandom_range(0, 15));
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      cycle();
    end
    rst_n = 1'b1;
    idle();
    cycle();
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
